// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Fetch-side program counter for the single-issue MIPS datapath. Forms the
//   branch / jump / jump-register targets, owns the PC register, drives the
//   instruction-memory request handshake and hands each fetched word to
//   decode together with its PC and PC+4.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   stall             : decode back-pressure, suppresses imem_req
//   br_taken, br_pc4, br_offset_sl2 : taken branch and its operands
//   jump, jump_index  : J/JAL redirect, region taken from br_pc4[31:28]
//   jr, jr_target     : JR/JALR redirect to a register value
//   imem_req/addr     : fetch request (address is the PC register)
//   imem_ready/rdata  : memory accept, instruction returned same cycle
//   inst_valid/data/pc/pc4 : delivered instruction, one-cycle valid pulse
//   misalign_err      : pulse when a JR target has nonzero low bits
//   fetch_count       : count of delivered (non-squashed) fetches
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_pc4,
    input  logic [31:0]        br_offset_sl2,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst_data,
    output logic [31:0]        inst_pc,
    output logic [31:0]        inst_pc4,
    output logic               misalign_err,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic        pending;
    logic [31:0] pending_target;

    logic        redirect;
    logic [31:0] target;
    logic        handshake;

    // Target selection with jr > jump > branch priority. The branch offset is
    // a signed displacement; the sum wraps modulo 2^32.
    function automatic logic [31:0] form_target(
        input logic        sel_jr,
        input logic        sel_jump,
        input logic [31:0] pc4,
        input logic [31:0] offset_sl2,
        input logic [25:0] index,
        input logic [31:0] reg_target
    );
        logic signed [31:0] pc4_s;
        logic signed [31:0] off_s;
        pc4_s = signed'(pc4);
        off_s = signed'(offset_sl2);
        if (sel_jr)
            form_target = {reg_target[31:2], 2'b00};
        else if (sel_jump)
            form_target = {pc4[31:28], index, 2'b00};
        else
            form_target = unsigned'(pc4_s + off_s);
    endfunction

    assign redirect  = jr | jump | br_taken;
    assign target    = form_target(jr, jump, br_pc4, br_offset_sl2, jump_index, jr_target);
    assign imem_req  = (state == ST_FETCH) && !stall;
    assign imem_addr = pc;
    assign handshake = imem_req && imem_ready;

    // Fetch stage -> decode delivery register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            pending        <= 1'b0;
            pending_target <= 32'h0;
            inst_valid     <= 1'b0;
            inst_data      <= 32'h0;
            inst_pc        <= 32'h0;
            inst_pc4       <= 32'h0;
            misalign_err   <= 1'b0;
            fetch_count    <= '0;
        end else begin
            inst_valid   <= 1'b0;
            misalign_err <= jr && (jr_target[1:0] != 2'b00);
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (redirect) begin
                        pending        <= 1'b1;
                        pending_target <= target;
                    end
                end
                ST_FETCH: begin
                    if (handshake) begin
                        if (redirect) begin
                            // Word fetched down the wrong path: drop it.
                            pc      <= target;
                            pending <= 1'b0;
                        end else if (pending) begin
                            // Redirect arrived while no fetch could complete;
                            // this word is still from the old path.
                            pc      <= pending_target;
                            pending <= 1'b0;
                        end else begin
                            inst_valid  <= 1'b1;
                            inst_data   <= imem_rdata;
                            inst_pc     <= pc;
                            inst_pc4    <= pc + 32'd4;
                            pc          <= pc + 32'd4;
                            fetch_count <= fetch_count + COUNT_W'(1);
                        end
                    end else if (redirect) begin
                        // Latest redirect wins if several arrive while waiting.
                        pending        <= 1'b1;
                        pending_target <= target;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jump, jr, imem_ready;
    logic [31:0] br_pc4, br_offset_sl2, jr_target;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, misalign_err;
    logic [31:0] inst_data, inst_pc, inst_pc4;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_branch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_pc4(br_pc4), .br_offset_sl2(br_offset_sl2),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit          m_fetch, m_pend;
    logic [31:0] m_pc, m_pt, m_count;
    bit          nxt_vld = 1'b0, nxt_mis = 1'b0;
    bit          exp_vld = 1'b0, exp_mis = 1'b0;
    bit          mon_en = 1'b0;

    // Redirect stimulus for the next cycle; cleared after each cycle.
    bit          r_br, r_jmp, r_jr;
    logic [31:0] r_pc4, r_off, r_jrt;
    logic [25:0] r_idx;

    task automatic cyc(input bit rst, input bit st, input bit rdy);
        bit          redir, hs, req;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        exp_vld = nxt_vld;
        exp_mis = nxt_mis;
        reset = rst; stall = st; imem_ready = rdy;
        br_taken = r_br; jump = r_jmp; jr = r_jr;
        br_pc4 = r_pc4; br_offset_sl2 = r_off; jump_index = r_idx; jr_target = r_jrt;

        redir = r_br | r_jmp | r_jr;
        if (r_jr)       tgt = r_jrt & 32'hFFFF_FFFC;
        else if (r_jmp) tgt = {r_pc4[31:28], r_idx, 2'b00};
        else            tgt = r_pc4 + r_off;
        req = m_fetch && !st;
        hs  = req && rdy;
        nxt_vld = 1'b0;
        nxt_mis = !rst && r_jr && (r_jrt[1:0] != 2'b00);
        if (rst) begin
            m_pc = 32'h0; m_fetch = 1'b0; m_pend = 1'b0; m_count = 32'h0;
        end else if (!m_fetch) begin
            m_fetch = 1'b1;
            if (redir) begin m_pend = 1'b1; m_pt = tgt; end
        end else if (hs) begin
            if (redir) begin
                m_pc = tgt; m_pend = 1'b0;
            end else if (m_pend) begin
                m_pc = m_pt; m_pend = 1'b0;
            end else begin
                m_count = m_count + 32'd1;
                sb.push_back('{data: mem_word(m_pc), pc: m_pc, pc4: m_pc + 32'd4, cnt: m_count});
                m_pc = m_pc + 32'd4;
                nxt_vld = 1'b1;
            end
        end else if (redir) begin
            m_pend = 1'b1; m_pt = tgt;
        end
        r_br = 1'b0; r_jmp = 1'b0; r_jr = 1'b0;
        @(negedge clk);
    endtask

    // Delivered-instruction scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            checks++;
            if (inst_valid !== exp_vld) begin
                errors++;
                $display("FAIL inst_valid: got %b expected %b at %0t", inst_valid, exp_vld, $time);
            end
            checks++;
            if (misalign_err !== exp_mis) begin
                errors++;
                $display("FAIL misalign_err: got %b expected %b at %0t", misalign_err, exp_mis, $time);
            end
            if (inst_valid === 1'b1 && exp_vld) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: inst_valid with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if (inst_data !== e.data || inst_pc !== e.pc || inst_pc4 !== e.pc4 ||
                        fetch_count !== e.cnt) begin
                        errors++;
                        $display("FAIL delivery: got data=%h pc=%h pc4=%h cnt=%0d expected data=%h pc=%h pc4=%h cnt=%0d",
                                 inst_data, inst_pc, inst_pc4, fetch_count, e.data, e.pc, e.pc4, e.cnt);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
            fetch_count !== 32'h0 || misalign_err !== 1'b0 || inst_pc !== 32'h0 ||
            inst_data !== 32'h0 || inst_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h vld=%b cnt=%0d mis=%b pc=%h data=%h pc4=%h required all zero",
                     imem_req, imem_addr, inst_valid, fetch_count, misalign_err, inst_pc, inst_data, inst_pc4);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        cyc(0, 0, 1);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b required 0", imem_req);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
                errors++;
                $display("FAIL stream_addr: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, 32'(i * 4));
            end
        end
    endtask

    task automatic test_ready_low();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold: got req=%b addr=%h required req=1 addr=00000010", imem_req, imem_addr);
            end
        end
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'h14 || inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_pc4 !== 32'h14) begin
            errors++;
            $display("FAIL wait_release: got addr=%h vld=%b inst_pc=%h pc4=%h required 00000014 1 00000010 00000014",
                     imem_addr, inst_valid, inst_pc, inst_pc4);
        end
    endtask

    task automatic test_branch();
        r_br = 1'b1; r_pc4 = 32'h24; r_off = 32'hFFFF_FFF0;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'h14 || inst_valid !== 1'b0 || fetch_count !== 32'd6) begin
            errors++;
            $display("FAIL branch_redirect: got addr=%h vld=%b cnt=%0d required 00000014 0 6",
                     imem_addr, inst_valid, fetch_count);
        end
    endtask

    task automatic test_jump_pending();
        r_jmp = 1'b1; r_pc4 = 32'h4000_0008; r_idx = 26'h0000100;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'h18) begin
            errors++;
            $display("FAIL jump_hold: got addr=%h required 00000018", imem_addr);
        end
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'h4000_0400 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_target: got addr=%h vld=%b required 40000400 0", imem_addr, inst_valid);
        end
    endtask

    task automatic test_jr_priority();
        r_jr = 1'b1; r_jrt = 32'h0000_1002; r_br = 1'b1; r_pc4 = 32'h24; r_off = 32'h8;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        checks++;
        if (imem_addr !== 32'h1000 || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL jr_misalign: got addr=%h mis=%b required 00001000 1", imem_addr, misalign_err);
        end
        cyc(0, 0, 0);
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got %b required 0", misalign_err);
        end
    endtask

    task automatic test_wrap();
        r_jr = 1'b1; r_jrt = 32'hFFFF_FFFC;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: got addr=%h required fffffffc", imem_addr);
        end
        cyc(0, 0, 1);
        checks++;
        if (imem_addr !== 32'h0 || inst_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: got addr=%h inst_pc4=%h required 00000000 00000000", imem_addr, inst_pc4);
        end
    endtask

    task automatic test_stall_reset();
        r_jr = 1'b1; r_jrt = 32'h20;
        cyc(0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1);
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h20) begin
                errors++;
                $display("FAIL stall_hold: got req=%b addr=%h required 0 00000020", imem_req, imem_addr);
            end
        end
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream: got req=%b addr=%h cnt=%0d vld=%b required 0 00000000 0 0",
                     imem_req, imem_addr, fetch_count, inst_valid);
        end
        cyc(0, 0, 1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL restart: got req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_pc4 = '0; br_offset_sl2 = '0; jump_index = '0; jr_target = '0;
        r_br = 1'b0; r_jmp = 1'b0; r_jr = 1'b0;
        r_pc4 = '0; r_off = '0; r_idx = '0; r_jrt = '0;
        m_fetch = 1'b0; m_pend = 1'b0; m_pc = '0; m_pt = '0; m_count = '0;

        test_reset();
        test_stream();
        test_ready_low();
        test_branch();
        test_jump_pending();
        test_jr_priority();
        test_wrap();
        test_stall_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected deliveries never seen, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Fetch-side program counter unit for the single-issue MIPS datapath. It sits directly downstream of the shift-left-2 stage and takes the already-shifted branch offset. It forms the branch, jump and jump-register targets, holds the PC register, and runs the instruction-memory request handshake. Each fetched instruction is delivered to decode with its PC and PC+4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
COUNT_W, 32, width of the completed-fetch counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode back-pressure; no new fetch completes while high
br_taken  input  1  resolved taken branch this cycle
br_pc4  input  32  PC+4 of the redirecting instruction (branch/jump)
br_offset_sl2  input  32  sign-extended immediate already shifted left by 2
jump  input  1  J/JAL redirect this cycle
jump_index  input  26  instr[25:0] of the jump
jr  input  1  JR/JALR redirect this cycle
jr_target  input  32  register value for JR
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= pc register)
imem_ready  input  1  memory accepts request and returns imem_rdata same cycle
imem_rdata  input  32  instruction word
inst_valid  output  1  one-cycle pulse: inst_data/inst_pc/inst_pc4 valid
inst_data  output  32  fetched instruction
inst_pc  output  32  address of inst_data
inst_pc4  output  32  inst_pc + 4
misalign_err  output  1  one-cycle pulse: jr_target[1:0] != 0
fetch_count  output  COUNT_W  number of non-squashed completed fetches

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - pc=RESET_PC, state=IDLE, pending=0.
  - imem_req=0, inst_valid=0, inst_data/inst_pc/inst_pc4=0, misalign_err=0, fetch_count=0.
- Target formation (combinational, mod 2^32):
  - branch: br_pc4 + br_offset_sl2
  - jump: {br_pc4[31:28], jump_index, 2'b00}
  - jr: {jr_target[31:2], 2'b00}
  - Priority when several assert: jr > jump > br_taken.
  - redirect = jr|jump|br_taken.
- misalign_err: registered; it pulses the cycle after jr=1 with jr_target[1:0]!=0. The redirect still proceeds to the truncated target.
- FSM:
  - IDLE: imem_req=0; next state FETCH unconditionally. Lasts one cycle after reset. A redirect seen in IDLE is captured as pending.
  - FETCH: imem_req = !stall; imem_addr=pc. A handshake completes when imem_req && imem_ready.
- On handshake:
  - No redirect this cycle and pending=0: inst_valid=1 next cycle; inst_data=imem_rdata, inst_pc=pc, inst_pc4=pc+4; pc<=pc+4; fetch_count++.
  - Redirect this cycle: fetched word squashed (inst_valid=0); pc<=new target; pending cleared.
  - Else, pending=1: word squashed; pc<=pending_target; pending<=0.
- No handshake (stall, or !imem_ready):
  - Redirect this cycle: pending<=1, pending_target<=new target. A later redirect overwrites it.
  - pc is held.
- inst_valid is a single-cycle pulse. inst_* hold their last values when inst_valid=0.
- stall=1 forces imem_req=0. imem_ready is ignored while imem_req=0.
- Fetch throughput: one per cycle with imem_ready tied high. Latency from handshake to inst_valid is 1 cycle.
- pc wraps 32'hFFFF_FFFC -> 0 without error. fetch_count wraps at 2^COUNT_W.
- Reset mid-fetch: the outstanding request is dropped, pending is cleared, and the IDLE cycle is re-entered.

Test Plan:
1. Reset then imem_ready=1 continuous -> cycle after reset imem_req=0. Then imem_addr 0,4,8,…; inst_valid pulses every cycle with inst_pc4=inst_pc+4; fetch_count increments by 1 each cycle.
2. imem_ready low 3 cycles at addr 0x10 -> imem_addr holds 0x10; no inst_valid. When ready rises: inst_pc=0x10, then addr 0x14.
3. br_taken with br_pc4=0x24, br_offset_sl2=0xFFFF_FFF0 during a handshake -> word squashed; next imem_addr=0x14; fetch_count unchanged that cycle.
4. jump with br_pc4=0x4000_0008, jump_index=0x0000100 while imem_ready=0 -> pending. Next handshake squashed; following imem_addr=0x4000_0400.
5. jr and br_taken together, jr_target=0x0000_1002 -> misalign_err pulses once; imem_addr becomes 0x1000 (jr priority).
6. stall=1 for 2 cycles with imem_ready=1, then reset asserted mid-stream at pc=0x20 -> imem_req=0 during stall with pc held. After reset: pc=RESET_PC, fetch_count=0, inst_valid=0, one IDLE cycle.
